spart_rx_fifo: RTL and testbench
================================

// Module: spart_rx_fifo
// PURPOSE
//   Byte FIFO that sits directly downstream of the SPART receiver.
//   Captures each received byte on the receiver's single-cycle rda strobe and buffers it.
//   The image-processing front end drains the FIFO at its own pace.
//   The FIFO is first-word-fall-through (FWFT) and reports a sticky overflow when bytes arrive while it is full.
// PARAMETERS
//   DEPTH     16   number of byte entries; power of two, >= 2
//   ADDR_W    4    log2(DEPTH)
//   AF_LEVEL  12   almost-full watermark; used only when SPART_RX_FIFO_AF_EN is defined
// PORTS
//   clk       in   1         system clock
//   rst_n     in   1         synchronous active-low reset
//   rx_data   in   8         received byte from SPART receiver
//   rda       in   1         byte-valid strobe; every high cycle is one write request
//   rd_en     in   1         pop request from consumer
//   rd_data   out  8         head-of-FIFO byte (FWFT)
//   empty     out  1         no entries stored
//   full      out  1         DEPTH entries stored
//   count     out  ADDR_W+1  entries stored, 0..DEPTH
//   overflow  out  1         sticky: a byte was dropped because the FIFO was full
//   clr_ovf   in   1         clears overflow
//   afull     out  1         count >= AF_LEVEL (only with SPART_RX_FIFO_AF_EN)
// BEHAVIOUR
//   - Reset (rst_n low at posedge clk), regardless of in-flight traffic:
//       wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, afull=0, rd_data=8'hFF.
//       Storage contents are not cleared.
//   - Pointers are ADDR_W bits and wrap from DEPTH-1 to 0.
//     count is a separate ADDR_W+1-bit register; empty and full are registered, derived from the next count.
//   - Write: rda & ~full -> mem[wr_ptr]<=rx_data, wr_ptr++ at the same edge.
//   - Read: rd_en & ~empty -> rd_ptr++.
//     rd_data always shows mem[rd_ptr] when ~empty and holds 8'hFF when empty.
//   - Write-to-read latency: a byte written at edge N is visible on rd_data, with empty=0, after edge N.
//     It is poppable in cycle N+1.
//   - Simultaneous rda & rd_en:
//       * not empty, not full: both occur, count unchanged.
//       * full: pop and push both occur. full stays 1. No overflow, because the write is evaluated against the pre-pop state only when rd_en is not also popping.
//       * empty: push occurs, pop ignored, count 0->1.
//   - Overflow: rda & full & ~rd_en -> byte dropped, overflow<=1.
//     Pointers and count are unchanged.
//   - Clearing overflow: clr_ovf in a cycle with no new overflow event -> overflow<=0.
//     If clr_ovf and a new overflow event occur in the same cycle, set wins.
//   - Underflow: rd_en & empty is ignored. No pointer change, no flag.
//   - count arithmetic is always exactly +1, -1 or 0 per cycle and never leaves 0..DEPTH.
// CONFIGURATION
//   SPART_RX_FIFO_AF_EN defined:
//     - afull is a registered flag, set when the next count >= AF_LEVEL and cleared when it drops below.
//     - Used as a flow-control hint to the host.
//     - AF_LEVEL must lie in 1..DEPTH.
//   SPART_RX_FIFO_AF_EN undefined:
//     - afull is tied to 0 and no comparator logic is built.
//     - All other behaviour is identical.
// TESTING
//   1. Reset then idle: rst_n low for 2 cycles -> empty=1, full=0, count=0, overflow=0, rd_data=8'hFF.
//   2. Basic FWFT: push 8'hA5, then 8'h3C on two rda pulses.
//      -> rd_data=A5 the cycle after the first push, count=2.
//      -> rd_en once gives rd_data=3C, count=1.
//      -> rd_en again gives empty=1, rd_data=FF.
//   3. Fill and overflow: push 16 bytes 8'h00..8'h0F -> full=1, count=16.
//      -> 17th push 8'hEE gives overflow=1, count=16.
//      -> draining yields 00..0F in order; EE is never seen.
//   4. Full with simultaneous push and pop: at full, rda=1 with 8'h77 and rd_en=1 in the same cycle.
//      -> count stays 16, overflow stays 0.
//      -> 8'h77 emerges after the 15 older bytes.
//   5. Wrap-around and clear: run 40 push/pop pairs with an increasing pattern.
//      -> pointers wrap, data order is preserved, count never exceeds 2.
//      -> clr_ovf pulse clears a previously set overflow.
//   6. Reset mid-operation and AF: with count=5, assert rst_n low for 1 cycle -> count=0, empty=1.
//      With SPART_RX_FIFO_AF_EN, AF_LEVEL=12:
//      -> afull rises on the 12th push and falls on the first pop.

Source files
------------

// File: rtl/spart_rx_fifo.sv
// rtl/spart_rx_fifo.sv - first-word-fall-through byte FIFO behind the SPART receiver, sticky overflow
// Optional almost-full flag built only when SPART_RX_FIFO_AF_EN is defined.
module spart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rda,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              afull
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_param
    $error("spart_rx_fifo: inconsistent DEPTH/ADDR_W/AF_LEVEL");
  end

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;

  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_pop  = rd_en & ~empty;
  assign do_push = rda & (~full | do_pop);
  assign ovf_evt = rda & full & ~rd_en;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CNT_ONE;
    else if (do_pop && !do_push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_C);
      if (ovf_evt)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign rd_data = empty ? 8'hFF : mem[rd_ptr];

`ifdef SPART_RX_FIFO_AF_EN
  localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);

  always_ff @(posedge clk) begin
    if (!rst_n)
      afull <= 1'b0;
    else
      afull <= (count_nxt >= AF_THR);
  end
`else
  assign afull = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_fifo.sv
// tb/tb_spart_rx_fifo.sv - self-checking bench for spart_rx_fifo against a queue reference model
module tb_spart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF_LEVEL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rda = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       afull;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;

  spart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rda(rda), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf), .afull(afull)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_n;
    bit         rda;
    logic [7:0] data;
    bit         rd_en;
    bit         clr;
    int         exp_count;
    bit         exp_empty;
    bit         exp_full;
    bit         exp_ovf;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_afull();
`ifdef SPART_RX_FIFO_AF_EN
    return mq.size() >= AF_LEVEL;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour: a bounded queue plus a sticky overflow bit.
  task automatic model_step(input bit r, input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit pop_ok, push_ok, ovf_ev;
    if (!r) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    pop_ok  = rd && mq.size() > 0;
    push_ok = wr && (mq.size() < DEPTH || pop_ok);
    ovf_ev  = wr && mq.size() == DEPTH && !rd;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(d);
    if (ovf_ev) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    rst_n = r; rda = wr; rx_data = d; rd_en = rd; clr_ovf = clr;
    model_step(r, wr, d, rd, clr);
    @(posedge clk);
    #1;
    rda = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; rst_n = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, int'(count), mq.size());
    chk({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
    chk({tag, ".full"}, int'(full), int'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ".rd_data"}, int'(rd_data), (mq.size() > 0) ? int'(mq[0]) : 32'hFF);
    chk({tag, ".afull"}, int'(afull), int'(exp_afull()));
  endtask

  initial begin
    // Reset, basic FWFT, underflow and empty push+pop cases.
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFF});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFF});
    vecs.push_back('{1, 1, 8'hA5, 0, 0, 1, 0, 0, 0, 8'hA5});
    vecs.push_back('{1, 1, 8'h3C, 0, 0, 2, 0, 0, 0, 8'hA5});
    vecs.push_back('{1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h3C});
    vecs.push_back('{1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'hFF});
    vecs.push_back('{1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'hFF});
    vecs.push_back('{1, 1, 8'h11, 1, 0, 1, 0, 0, 0, 8'h11});
    vecs.push_back('{1, 1, 8'h22, 1, 0, 1, 0, 0, 0, 8'h22});
    vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'hFF});

    #1;
    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].rda, vecs[i].data, vecs[i].rd_en, vecs[i].clr);
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].exp_full));
      chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d.afull", i), int'(afull), 0);
    end

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(i), 0, 0);
    chk("fill.full", int'(full), 1);
    chk("fill.count", int'(count), 16);
    cyc(1, 1, 8'hEE, 0, 0);
    chk("ovf.set", int'(overflow), 1);
    chk("ovf.count", int'(count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.data", int'(rd_data), i);
      cyc(1, 0, 8'h00, 1, 0);
    end
    chk_model("drained");

    // Full with simultaneous push and pop.
    cyc(1, 0, 8'h00, 0, 1);
    chk("clr.ovf", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(8'h40 + i), 0, 0);
    cyc(1, 1, 8'h77, 1, 0);
    chk("fullrw.count", int'(count), 16);
    chk("fullrw.overflow", int'(overflow), 0);
    chk("fullrw.full", int'(full), 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("fullrw.data", int'(rd_data), 8'h40 + i);
      cyc(1, 0, 8'h00, 1, 0);
    end
    chk("fullrw.last", int'(rd_data), 8'h77);
    cyc(1, 0, 8'h00, 1, 0);
    chk_model("fullrw.end");

    // Wrap-around with an overflow left set, then cleared.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'hEE, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 8'(i + 8'h80), 0, 0);
      chk("wrap.data", int'(rd_data), i + 8'h80);
      chk("wrap.cnt_le2", int'(count <= 2), 1);
      cyc(1, 0, 8'h00, 1, 0);
    end
    chk("wrap.ovf_held", int'(overflow), 1);
    cyc(1, 0, 8'h00, 0, 1);
    chk_model("wrap.clr");

    // Clear and new overflow in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(i), 0, 0);
    cyc(1, 1, 8'hEE, 0, 1);
    chk_model("setwins");

    // Reset mid-operation, then almost-full walk.
    cyc(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'(i), 0, 0);
    chk("midrst.pre", int'(count), 5);
    cyc(0, 1, 8'h99, 1, 0);
    chk_model("midrst");
    for (int i = 0; i < AF_LEVEL; i++) begin
      cyc(1, 1, 8'(i), 0, 0);
      chk_model("af.push");
    end
    cyc(1, 0, 8'h00, 1, 0);
    chk_model("af.pop");

    // Randomized phases against the queue model.
    for (int n = 0; n < 3000; n++) begin
      int ph;
      bit wr, rd, clr, r;
      ph  = (n / 200) % 3;
      wr  = ($urandom_range(0, 99) < (ph == 0 ? 80 : ph == 1 ? 30 : 50));
      rd  = ($urandom_range(0, 99) < (ph == 0 ? 30 : ph == 1 ? 80 : 50));
      clr = ($urandom_range(0, 99) < 5);
      r   = ($urandom_range(0, 999) >= 3);
      cyc(r, wr, 8'($urandom), rd, clr);
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
